// File: rtl/io_bus_slave_pkg.sv
// iobus_pkg: shared state encoding and sizing constants for the PDS I/O bus slave.
package iobus_pkg;
   typedef enum logic [2:0] {IDLE, REQ, ACT, SETTLE, DRAIN, WAITEND} stateT;
   localparam int CNT_W = 8;
   localparam int DEF_TIMEOUT = 255;
   localparam int DEF_RD_SETTLE = 1;
endpackage

// File: rtl/io_bus_slave_if.sv
// io_bus_slave_if: CPU-side cycle attributes plus the IOREQ/IOACT handshake to the I/O bus master.
interface io_bus_slave_if;
   logic BACT, IOCS, CPUWE, CPULDS, CPUUDS;
   logic IORDY, IOBERR;
   logic IOREQ, IOACT, nADLEEN;
   logic IOWE, IOLDS, IOUDS;
   modport slave (
      input BACT, IOCS, CPUWE, CPULDS, CPUUDS, IOACT,
      output IORDY, IOBERR, IOREQ, nADLEEN, IOWE, IOLDS, IOUDS
   );
   modport master (
      output BACT, IOCS, CPUWE, CPULDS, CPUUDS, IOACT,
      input IORDY, IOBERR, IOREQ, nADLEEN, IOWE, IOLDS, IOUDS
   );
endinterface

// File: rtl/io_bus_slave_watchdog.sv
// io_watchdog: saturating cycle counter; expired flags the enabled edge on which the count reaches LIMIT.
module io_watchdog import iobus_pkg::*; #(
   parameter int LIMIT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [CNT_W-1:0] count;
   assign expired = en && (count >= CNT_W'(LIMIT - 1));
   always_ff @(posedge clk)
      if (rst || clr) count <= '0;
      else if (en && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/io_bus_slave.sv
// io_bus_slave: registers CPU I/O cycle attributes, runs IOREQ/IOACT with the I/O bus master,
// and returns a one-cycle IORDY or IOBERR pulse to the CPU bus controller.
module io_bus_slave import iobus_pkg::*; #(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int RD_SETTLE = DEF_RD_SETTLE
) (
   input logic C16M,
   input logic RST,
   io_bus_slave_if.slave bus
);
   stateT state;
   logic [1:0] settleCnt;
   logic wdEn, expired;
   assign wdEn = state == REQ || state == ACT;
   io_watchdog #(.LIMIT(TIMEOUT)) wd (
      .clk(C16M), .rst(RST), .clr(!wdEn), .en(wdEn), .expired(expired)
   );
   // Completion is checked before expiry, so IOACT falling on the timeout edge still yields IORDY.
   always_ff @(posedge C16M)
      if (RST) begin
         state <= IDLE;
         settleCnt <= '0;
         bus.IOREQ <= 1'b0;
         bus.nADLEEN <= 1'b1;
         bus.IORDY <= 1'b0;
         bus.IOBERR <= 1'b0;
         bus.IOWE <= 1'b0;
         bus.IOLDS <= 1'b0;
         bus.IOUDS <= 1'b0;
      end else begin
         bus.IORDY <= 1'b0;
         bus.IOBERR <= 1'b0;
         case (state)
            IDLE: if (bus.BACT && bus.IOCS && !bus.IOACT) begin
               bus.IOWE <= bus.CPUWE;
               bus.IOLDS <= bus.CPULDS;
               bus.IOUDS <= bus.CPUUDS;
               bus.IOREQ <= 1'b1;
               bus.nADLEEN <= 1'b0;
               state <= REQ;
            end
            REQ: if (bus.IOACT) begin
               bus.IOREQ <= 1'b0;
               bus.nADLEEN <= 1'b1;
               state <= ACT;
            end else if (expired) begin
               bus.IOREQ <= 1'b0;
               bus.nADLEEN <= 1'b1;
               bus.IOBERR <= bus.BACT;
               state <= WAITEND;
            end
            ACT: if (!bus.IOACT) begin
               if (bus.IOWE || RD_SETTLE == 0) begin
                  bus.IORDY <= bus.BACT;
                  state <= WAITEND;
               end else begin
                  settleCnt <= '0;
                  state <= SETTLE;
               end
            end else if (expired) begin
               bus.IOBERR <= bus.BACT;
               state <= DRAIN;
            end
            SETTLE: if (settleCnt == 2'(RD_SETTLE - 1)) begin
               bus.IORDY <= bus.BACT;
               state <= WAITEND;
            end else settleCnt <= settleCnt + 1'b1;
            DRAIN: if (!bus.IOACT) state <= WAITEND;
            WAITEND: if (!bus.BACT) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_io_bus_slave.sv
// tb_io_bus_slave: vector table for reset/basic cycles, hand sequences for timeout, abort and race cases.
module tb_io_bus_slave;
   logic C16M = 1'b0;
   logic RST = 1'b1;
   io_bus_slave_if bus();
   io_bus_slave #(.TIMEOUT(16), .RD_SETTLE(1)) dut (.C16M(C16M), .RST(RST), .bus(bus));
   always #5 C16M = ~C16M;
   localparam logic [6:0] mReq = 7'b1000000, mAdl = 7'b0100000, mRdy = 7'b0010000,
      mBerr = 7'b0001000, mWe = 7'b0000100, mLds = 7'b0000010, mUds = 7'b0000001;
   typedef struct { logic [6:0] in; logic [6:0] out; } vecT;
   vecT vecs[18];
   int checks = 0, errors = 0;
   function automatic logic [6:0] outs();
      return {bus.IOREQ, bus.nADLEEN, bus.IORDY, bus.IOBERR, bus.IOWE, bus.IOLDS, bus.IOUDS};
   endfunction
   task automatic tick();
      @(posedge C16M);
      #1;
   endtask
   task automatic chk(input string n, input logic [6:0] m, input logic [6:0] e);
      logic [6:0] a;
      a = outs() & m;
      checks++;
      if (a !== (e & m)) begin
         errors++;
         $display("FAIL %s: got %b want %b (mask %b) at %0t", n, a, e & m, m, $time);
      end
   endtask
   task automatic setCpu(input logic bact, input logic we, input logic lds, input logic uds);
      bus.BACT = bact;
      bus.IOCS = 1'b1;
      bus.CPUWE = we;
      bus.CPULDS = lds;
      bus.CPUUDS = uds;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got running want done");
      $fatal(1);
   end
   initial begin
      // inputs {RST,BACT,IOCS,CPUWE,CPULDS,CPUUDS,IOACT}; outputs {IOREQ,nADLEEN,IORDY,IOBERR,IOWE,IOLDS,IOUDS}
      vecs[0] = '{7'b1111111, 7'b0100000};
      vecs[1] = '{7'b1111111, 7'b0100000};
      vecs[2] = '{7'b0111111, 7'b0100000};
      vecs[3] = '{7'b0111111, 7'b0100000};
      vecs[4] = '{7'b0111110, 7'b1000111};
      vecs[5] = '{7'b0111110, 7'b1000111};
      vecs[6] = '{7'b0111111, 7'b0100111};
      vecs[7] = '{7'b0111111, 7'b0100111};
      vecs[8] = '{7'b0111110, 7'b0110111};
      vecs[9] = '{7'b0110100, 7'b0100111};
      vecs[10] = '{7'b0110100, 7'b0100111};
      vecs[11] = '{7'b0000100, 7'b0100111};
      vecs[12] = '{7'b0100100, 7'b0100111};
      vecs[13] = '{7'b0110100, 7'b1000010};
      vecs[14] = '{7'b0110101, 7'b0100010};
      vecs[15] = '{7'b0110100, 7'b0100010};
      vecs[16] = '{7'b0110100, 7'b0110010};
      vecs[17] = '{7'b0000100, 7'b0100010};
      for (int i = 0; i < 18; i++) begin
         {RST, bus.BACT, bus.IOCS, bus.CPUWE, bus.CPULDS, bus.CPUUDS, bus.IOACT} = vecs[i].in;
         tick();
         chk($sformatf("vec%0d", i), 7'h7f, vecs[i].out);
      end
      // read, IOACT up 2 cycles after IOREQ for 10 cycles
      setCpu(1'b1, 1'b0, 1'b1, 1'b0);
      bus.IOACT = 1'b0;
      tick(); chk("rdReqRise", mReq | mAdl, mReq);
      repeat (2) begin tick(); chk("rdReqHold", mReq | mAdl | mLds | mUds, mReq | mLds); end
      bus.IOACT = 1'b1;
      tick(); chk("rdReqDrop", mReq | mAdl, mAdl);
      for (int i = 0; i < 9; i++) begin
         tick(); chk("rdActHold", mReq | mRdy | mBerr | mLds | mUds, mLds);
      end
      bus.IOACT = 1'b0;
      tick(); chk("rdSettle", mRdy | mBerr, 7'b0);
      tick(); chk("rdRdy", mRdy | mBerr | mLds | mUds, mRdy | mLds);
      tick(); chk("rdRdyOnce", mRdy | mReq, 7'b0);
      bus.BACT = 1'b0;
      tick();
      // write both lanes, BACT lingers
      setCpu(1'b1, 1'b1, 1'b1, 1'b1);
      tick(); chk("wrReqRise", mReq | mWe, mReq | mWe);
      bus.IOACT = 1'b1;
      tick(); chk("wrAct", mReq | mWe, mWe);
      repeat (2) tick();
      bus.IOACT = 1'b0;
      tick(); chk("wrRdy", mRdy | mBerr | mWe | mLds | mUds, mRdy | mWe | mLds | mUds);
      repeat (5) begin tick(); chk("wrNoReissue", mReq | mRdy, 7'b0); end
      bus.BACT = 1'b0;
      tick();
      // timeout in REQ
      setCpu(1'b1, 1'b0, 1'b1, 1'b1);
      tick(); chk("toReqRise", mReq, mReq);
      for (int i = 1; i < 16; i++) begin tick(); chk("toReqWait", mReq | mBerr, mReq); end
      tick(); chk("toReqBerr", mReq | mBerr | mRdy | mAdl, mBerr | mAdl);
      tick(); chk("toReqAfter", mReq | mBerr | mRdy, 7'b0);
      bus.BACT = 1'b0;
      tick(); chk("toReqIdle", mReq, 7'b0);
      // timeout in ACT, IOACT held 40 cycles
      setCpu(1'b1, 1'b1, 1'b0, 1'b1);
      tick(); chk("toActRise", mReq, mReq);
      bus.IOACT = 1'b1;
      for (int i = 1; i < 16; i++) begin tick(); chk("toActWait", mReq | mBerr, 7'b0); end
      tick(); chk("toActBerr", mBerr | mRdy, mBerr);
      for (int i = 17; i <= 40; i++) begin tick(); chk("toActDrain", mReq | mBerr | mRdy, 7'b0); end
      bus.IOACT = 1'b0;
      repeat (3) begin tick(); chk("toActWaitEnd", mReq | mRdy, 7'b0); end
      bus.BACT = 1'b0;
      repeat (2) begin tick(); chk("toActIdle", mReq, 7'b0); end
      // IOACT falls on the timeout edge: completion wins
      setCpu(1'b1, 1'b1, 1'b1, 1'b0);
      tick(); chk("raceRise", mReq, mReq);
      bus.IOACT = 1'b1;
      for (int i = 1; i < 16; i++) begin tick(); chk("raceWait", mBerr | mRdy, 7'b0); end
      bus.IOACT = 1'b0;
      tick(); chk("raceRdy", mRdy | mBerr, mRdy);
      tick(); chk("raceOnce", mRdy | mBerr, 7'b0);
      bus.BACT = 1'b0;
      tick();
      // CPU abort 3 cycles into ACT
      setCpu(1'b1, 1'b1, 1'b1, 1'b1);
      tick(); chk("abRise", mReq, mReq);
      bus.IOACT = 1'b1;
      repeat (3) tick();
      bus.BACT = 1'b0;
      repeat (3) begin tick(); chk("abHold", mReq | mRdy | mBerr, 7'b0); end
      bus.IOACT = 1'b0;
      tick(); chk("abDone", mRdy | mBerr, 7'b0);
      tick(); chk("abIdle", mReq | mRdy | mBerr, 7'b0);
      setCpu(1'b1, 1'b0, 1'b0, 1'b1);
      tick(); chk("abNext", mReq | mAdl | mWe | mLds | mUds, mReq | mUds);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/io_bus_slave.md
Name: io_bus_slave

Overview:
- Upstream neighbour of the PDS I/O bus master.
- Accepts CPU-side I/O cycles decoded by the address decoder and registers the cycle attributes (write, byte lanes).
- Runs the IOREQ/IOACT handshake with the I/O bus master and returns a one-cycle ready or bus-error pulse to the CPU bus controller.
- Holds the transaction attributes stable for the whole I/O bus cycle and enforces a watchdog timeout.

Parameters:
TIMEOUT, 255, C16M cycles from IOREQ assertion to forced bus error (1..255).
RD_SETTLE, 1, extra C16M cycles after IOACT falls before a read ready pulse (0..3).

Ports:
C16M  input  1  16 MHz system clock; all logic on posedge.
RST  input  1  synchronous reset, active-high.
BACT  input  1  CPU bus cycle active.
IOCS  input  1  address decoder: current cycle targets the I/O bus.
CPUWE  input  1  current CPU cycle is a write.
CPULDS  input  1  lower byte lane selected.
CPUUDS  input  1  upper byte lane selected.
IORDY  output  1  one-cycle pulse: I/O cycle complete (read data latched, or write done).
IOBERR  output  1  one-cycle pulse: I/O cycle timed out.
IOREQ  output  1  request to the I/O bus master.
IOACT  input  1  I/O bus master busy.
nADLEEN  output  1  low = PDS address/data output latch transparent.
IOWE  output  1  registered write flag.
IOLDS  output  1  registered lower strobe.
IOUDS  output  1  registered upper strobe.

Behaviour:
- Clocking and reset:
  - One clock, C16M. RST is synchronous and active-high.
  - Reset values: IOREQ=0, nADLEEN=1, IORDY=0, IOBERR=0, IOWE=0, IOLDS=0, IOUDS=0, state IDLE, timeout counter 0.
- IDLE:
  - Start condition: BACT & IOCS & ~IOACT.
  - On start, register CPUWE/CPULDS/CPUUDS into IOWE/IOLDS/IOUDS, assert IOREQ and drive nADLEEN=0 from the next edge, then go to REQ.
  - IOACT high blocks the start. This covers reset asserted mid-transaction: no new request until the master drains.
- REQ:
  - IOREQ=1 and nADLEEN=0.
  - On IOACT=1: IOREQ=0 and nADLEEN=1 from the next edge, then go to ACT.
  - Timeout counter increments each cycle in REQ and ACT.
  - Counter reaching TIMEOUT in REQ: drop IOREQ, pulse IOBERR, go to WAITEND.
- ACT:
  - On IOACT=0, for a write: pulse IORDY the next cycle, go to WAITEND.
  - On IOACT=0, for a read: go to SETTLE, or behave as a write if RD_SETTLE=0.
  - Counter reaching TIMEOUT in ACT: pulse IOBERR, go to DRAIN.
- SETTLE:
  - Count RD_SETTLE cycles, then pulse IORDY and go to WAITEND.
- DRAIN:
  - Wait for IOACT=0, then go to WAITEND. No IORDY is issued.
- WAITEND:
  - Wait for BACT=0, then go to IDLE. This prevents the same CPU cycle from being issued twice.
- Attribute stability:
  - IOWE/IOLDS/IOUDS are constant from the start until the block re-enters IDLE.
  - They update only on a start.
- CPU abort (BACT falls in REQ or ACT):
  - The handshake still completes.
  - IORDY and IOBERR are suppressed if BACT=0 on the completion cycle.
- Simultaneous events:
  - IOACT falling on the same edge the counter reaches TIMEOUT: completion wins, and IORDY is issued with no IOBERR.
- Pulse rules:
  - IORDY and IOBERR are never high together.
  - Each is high for exactly one cycle per transaction.
- Latency:
  - Start edge to IOREQ high: 1 cycle.
  - IOACT falling edge to IORDY: 1 cycle for writes, 1+RD_SETTLE cycles for reads.

Decomposition:
- Shared package iobus_pkg holds:
  - state enum: IDLE, REQ, ACT, SETTLE, DRAIN, WAITEND;
  - TIMEOUT counter width constant (8);
  - default TIMEOUT and RD_SETTLE values.
- One natural sub-module: io_watchdog, an 8-bit saturating counter with clear/enable/expired outputs.
- The FSM and attribute registers stay in io_bus_slave.

Test Plan:
- Reset: RST high for 2 cycles while IOACT=1 -> all outputs at reset values; with BACT&IOCS high, no IOREQ until IOACT=0, then IOREQ rises 1 cycle later.
- Read, CPULDS=1, CPUUDS=0, master model raises IOACT 2 cycles after IOREQ and drops it 10 cycles later -> IOREQ high 3 cycles, nADLEEN low for the same window, IOLDS=1 and IOUDS=0 stable throughout, IORDY pulses exactly 2 cycles after IOACT falls (RD_SETTLE=1).
- Write, both lanes -> IOWE=1 held; IORDY pulses 1 cycle after IOACT falls; BACT held high 5 more cycles -> no second IOREQ.
- Timeout in REQ with TIMEOUT=16 and IOACT never rising -> IOBERR pulses 16 cycles after IOREQ rose, IOREQ low thereafter, no IORDY.
- Timeout in ACT with TIMEOUT=16 and IOACT held 40 cycles -> IOBERR at cycle 16; no new IOREQ until IOACT falls and BACT returns low; IOACT falling on the TIMEOUT edge instead -> IORDY only.
- Abort: BACT drops 3 cycles into ACT -> handshake completes, no IORDY or IOBERR, return to IDLE; next cycle issues normally.
